// File: rtl/instr_encoder_pkg.sv
// Shared instruction-word types for the encoder/loader and the decode stage.
// Every field view of instr_t uses the same bit layout: op, dst, src1, src2, 15-bit tail.
package common;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  regid_t;

  typedef enum logic [4:0] {
    OP_ADD      = 5'd0,
    OP_SUB      = 5'd1,
    OP_MUL      = 5'd2,
    OP_MOV      = 5'd3,
    OP_LDB      = 5'd4,
    OP_LDW      = 5'd5,
    OP_STB      = 5'd6,
    OP_STW      = 5'd7,
    OP_BEQ      = 5'd8,
    OP_JUMP     = 5'd9,
    OP_TLBWRITE = 5'd10,
    OP_IRET     = 5'd11
  } opcode_t;

  typedef enum logic [1:0] {
    TLB_OFF  = 2'd0,
    TLB_ITLB = 2'd1,
    TLB_DTLB = 2'd2
  } tlbwrite_t;

  localparam int IMM_W = 15;
  localparam logic [IMM_W-1:0] TLBSEL_ITLB = 15'd0;
  localparam logic [IMM_W-1:0] TLBSEL_DTLB = 15'd1;

  typedef struct packed {
    regid_t           dst;
    regid_t           src1;
    regid_t           src2;
    logic [IMM_W-1:0] pad;
  } r_fields_t;

  typedef struct packed {
    regid_t           dst;
    regid_t           src1;
    regid_t           src2;
    logic [IMM_W-1:0] immediate;
  } m_fields_t;

  typedef struct packed {
    regid_t           dst;
    regid_t           src1;
    regid_t           src2;
    logic [IMM_W-1:0] offset_lo;
  } b_fields_t;

  typedef union packed {
    r_fields_t r;
    m_fields_t m;
    b_fields_t b;
  } fields_t;

  typedef struct packed {
    opcode_t op;
    fields_t fields;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } loader_state_t;

  function automatic logic is_imm_op(opcode_t op);
    case (op)
      OP_LDB, OP_LDW, OP_STB, OP_STW, OP_BEQ, OP_JUMP: is_imm_op = 1'b1;
      default:                                         is_imm_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Small FIFO of encoded instruction words; clear empties it synchronously.
module instr_fifo
  import common::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   push,
  input  logic   pop,
  input  instr_t wdata,
  output instr_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  instr_t           mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rdata = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs field-level requests into instr_t words and writes them to memory
// sequentially from a programmable base address.
module instr_encoder
  import common::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  opcode_t           req_op,
  input  regid_t            req_dst,
  input  regid_t            req_r1,
  input  regid_t            req_r2,
  input  word_t             req_imm,
  input  tlbwrite_t         req_tlb,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output instr_t            mem_wdata,
  output logic              err,
  output logic              busy,
  output logic              done,
  output logic [15:0]       count
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  loader_state_t     state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       cnt;
  instr_t            enc;
  instr_t            head;
  logic              bad_op;
  logic              reject;
  logic              accept;
  logic              push;
  logic              pop;
  logic              clear;
  logic              full;
  logic              empty;

  always_comb begin
    enc    = '0;
    enc.op = req_op;
    bad_op = 1'b0;
    case (req_op)
      OP_ADD, OP_SUB, OP_MUL, OP_MOV: begin
        enc.fields.r.dst  = req_dst;
        enc.fields.r.src1 = req_r1;
        enc.fields.r.src2 = req_r2;
      end
      OP_LDB, OP_LDW: begin
        enc.fields.m.dst       = req_dst;
        enc.fields.m.src1      = req_r1;
        enc.fields.m.immediate = req_imm[IMM_W-1:0];
      end
      OP_STB, OP_STW, OP_BEQ: begin
        enc.fields.m.src1      = req_r1;
        enc.fields.m.src2      = req_r2;
        enc.fields.m.immediate = req_imm[IMM_W-1:0];
      end
      OP_JUMP: begin
        enc.fields.m.src1      = req_r1;
        enc.fields.m.immediate = req_imm[IMM_W-1:0];
      end
      OP_TLBWRITE: begin
        enc.fields.b.src1      = req_r1;
        enc.fields.b.src2      = req_r2;
        enc.fields.b.offset_lo = (req_tlb == TLB_DTLB) ? TLBSEL_DTLB : TLBSEL_ITLB;
      end
      OP_IRET: ;
      default: bad_op = 1'b1;
    endcase
  end

  // Rejected requests still complete the handshake; they are just not enqueued.
  assign reject = bad_op ||
                  (is_imm_op(req_op) && (|req_imm[31:IMM_W])) ||
                  ((req_op == OP_TLBWRITE) && (req_tlb == TLB_OFF));

  assign req_ready = (state == LOAD) && !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && !reject;
  assign pop       = !empty && mem_ready;
  assign clear     = (state == IDLE) && start;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (enc),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign mem_valid = !empty;
  assign mem_wdata = empty ? '0 : head;
  assign mem_addr  = addr;
  assign busy      = (state != IDLE);
  assign done      = (state == DRAIN) && empty;
  assign count     = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      err <= accept && reject;
      if (pop) begin
        addr <= addr + STEP;
        if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          addr  <= base_addr;
          cnt   <= '0;
        end
        LOAD:    if (finish) state <= DRAIN;
        DRAIN:   if (empty) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
